pipe_control_unit: RTL

//   Parametrised pipelined successor of the single-cycle decoder. Decodes the ID-stage opcode

---
 rtl/pipe_control_unit.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_control_unit.sv
// ----------------------------------------------------------------------------
// pipe_control_unit
//
// Pipelined control path for a small load/store CPU. The opcode sitting in the
// ID stage is decoded into a control bundle, which then travels through the
// ID/EX, EX/MEM and MEM/WB registers alongside the datapath. The unit also:
//   - stalls ID for one cycle when a load in EX feeds a register read in ID
//     and injects a bubble into EX,
//   - squashes the ID slot that follows an accepted jump,
//   - counts instructions that leave WB.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   id_valid            ID slot holds a real instruction
//   id_opcode           ID opcode (bits above [2] must be zero to be legal)
//   id_rs, id_rt        ID source register fields (rt is the I-type dest)
//   id_rd               ID R-type destination field
//   id_stall            hold PC and IF/ID this cycle (combinational)
//   id_jump             jump accepted in ID this cycle (combinational)
//   illegal             accepted ID opcode is undefined (combinational)
//   ex_alusrc, ex_aluop EX-stage controls (aluop: 00 add 01 sub 10 and 11 or)
//   mem_read, mem_write MEM-stage controls
//   wb_regwrite         WB: write the register file
//   wb_memtoreg         WB: select memory data
//   wb_dest             WB destination register
//   retired             count of valid instructions that have left WB
// ----------------------------------------------------------------------------
module pipe_control_unit #(
  parameter int OPC_W = 3,
  parameter int REG_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  output logic             id_stall,
  output logic             id_jump,
  output logic             illegal,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic [REG_W-1:0] wb_dest,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] OP_LW   = 3'b000;
  localparam logic [2:0] OP_SW   = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  // Decoded bundle of the ID slot
  logic             dec_alusrc;
  logic [1:0]       dec_aluop;
  logic             dec_memread;
  logic             dec_memwrite;
  logic             dec_regwrite;
  logic             dec_memtoreg;
  logic [REG_W-1:0] dec_dest;
  logic             dec_uses_rt;
  logic             dec_jmp;
  logic             illegal_op;
  logic [OPC_W-1:0] opc_hi;
  logic             accepted;
  logic             squash_q;

  // ID/EX register
  logic             ex_valid_q,    ex_valid_d;
  logic             ex_alusrc_q,   ex_alusrc_d;
  logic [1:0]       ex_aluop_q,    ex_aluop_d;
  logic             ex_memread_q,  ex_memread_d;
  logic             ex_memwrite_q, ex_memwrite_d;
  logic             ex_regwrite_q, ex_regwrite_d;
  logic             ex_memtoreg_q, ex_memtoreg_d;
  logic [REG_W-1:0] ex_dest_q,     ex_dest_d;

  // EX/MEM register
  logic             mem_valid_q;
  logic             mem_memread_q;
  logic             mem_memwrite_q;
  logic             mem_regwrite_q;
  logic             mem_memtoreg_q;
  logic [REG_W-1:0] mem_dest_q;

  // MEM/WB register
  logic             wb_valid_q;
  logic             wb_regwrite_q;
  logic             wb_memtoreg_q;
  logic [REG_W-1:0] wb_dest_q;

  logic [CNT_W-1:0] retired_q;

  // Any opcode bit above [2] makes the opcode undefined; for OPC_W == 3 the
  // shifted value is always zero.
  assign opc_hi     = id_opcode >> 3;
  assign illegal_op = |opc_hi;

  // Opcode decode. An illegal opcode keeps the all-zero default bundle and
  // neither reads rt nor counts as a jump.
  always_comb begin
    dec_alusrc   = 1'b0;
    dec_aluop    = 2'b00;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_regwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_dest     = '0;
    dec_uses_rt  = 1'b0;
    dec_jmp      = 1'b0;
    if (!illegal_op) begin
      case (id_opcode[2:0])
        OP_LW: begin
          dec_alusrc   = 1'b1;
          dec_memread  = 1'b1;
          dec_regwrite = 1'b1;
          dec_memtoreg = 1'b1;
          dec_dest     = id_rt;
        end
        OP_SW: begin
          dec_alusrc   = 1'b1;
          dec_memwrite = 1'b1;
          dec_uses_rt  = 1'b1;
        end
        OP_JMP: begin
          dec_jmp = 1'b1;
        end
        OP_ADD: begin
          dec_regwrite = 1'b1;
          dec_dest     = id_rd;
          dec_aluop    = 2'b00;
          dec_uses_rt  = 1'b1;
        end
        OP_ADDI: begin
          dec_alusrc   = 1'b1;
          dec_regwrite = 1'b1;
          dec_dest     = id_rt;
        end
        OP_SUB: begin
          dec_regwrite = 1'b1;
          dec_dest     = id_rd;
          dec_aluop    = 2'b01;
          dec_uses_rt  = 1'b1;
        end
        OP_AND: begin
          dec_regwrite = 1'b1;
          dec_dest     = id_rd;
          dec_aluop    = 2'b10;
          dec_uses_rt  = 1'b1;
        end
        OP_OR: begin
          dec_regwrite = 1'b1;
          dec_dest     = id_rd;
          dec_aluop    = 2'b11;
          dec_uses_rt  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Load-use hazard: a load in EX whose destination is read by the ID slot.
  // The bubble it injects clears ex_memread, so the stall lasts one cycle.
  // A squashed slot never stalls.
  assign id_stall = id_valid & ~squash_q & ex_memread_q &
                    ((ex_dest_q == id_rs) | (dec_uses_rt & (ex_dest_q == id_rt)));
  assign accepted = id_valid & ~squash_q & ~id_stall;
  assign id_jump  = accepted & dec_jmp;
  assign illegal  = accepted & illegal_op;

  // Anything not accepted enters ID/EX as an all-zero bubble.
  always_comb begin
    ex_valid_d    = 1'b0;
    ex_alusrc_d   = 1'b0;
    ex_aluop_d    = 2'b00;
    ex_memread_d  = 1'b0;
    ex_memwrite_d = 1'b0;
    ex_regwrite_d = 1'b0;
    ex_memtoreg_d = 1'b0;
    ex_dest_d     = '0;
    if (accepted) begin
      ex_valid_d    = 1'b1;
      ex_alusrc_d   = dec_alusrc;
      ex_aluop_d    = dec_aluop;
      ex_memread_d  = dec_memread;
      ex_memwrite_d = dec_memwrite;
      ex_regwrite_d = dec_regwrite;
      ex_memtoreg_d = dec_memtoreg;
      ex_dest_d     = dec_dest;
    end
  end

  // Pipeline registers, squash flag and retire counter. EX/MEM and MEM/WB
  // advance every cycle; only ID is ever held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squash_q       <= 1'b0;
      ex_valid_q     <= 1'b0;
      ex_alusrc_q    <= 1'b0;
      ex_aluop_q     <= 2'b00;
      ex_memread_q   <= 1'b0;
      ex_memwrite_q  <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_memtoreg_q  <= 1'b0;
      ex_dest_q      <= '0;
      mem_valid_q    <= 1'b0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_dest_q     <= '0;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_dest_q      <= '0;
      retired_q      <= '0;
    end else begin
      squash_q       <= id_jump;
      ex_valid_q     <= ex_valid_d;
      ex_alusrc_q    <= ex_alusrc_d;
      ex_aluop_q     <= ex_aluop_d;
      ex_memread_q   <= ex_memread_d;
      ex_memwrite_q  <= ex_memwrite_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memtoreg_q  <= ex_memtoreg_d;
      ex_dest_q      <= ex_dest_d;
      mem_valid_q    <= ex_valid_q;
      mem_memread_q  <= ex_memread_q;
      mem_memwrite_q <= ex_memwrite_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_memtoreg_q <= ex_memtoreg_q;
      mem_dest_q     <= ex_dest_q;
      wb_valid_q     <= mem_valid_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_dest_q      <= mem_dest_q;
      if (wb_valid_q) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign ex_alusrc   = ex_alusrc_q;
  assign ex_aluop    = ex_aluop_q;
  assign mem_read    = mem_memread_q;
  assign mem_write   = mem_memwrite_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_memtoreg = wb_memtoreg_q;
  assign wb_dest     = wb_dest_q;
  assign retired     = retired_q;

endmodule
